// File: rtl/dp_memory.sv
// Simple dual-port RAM with byte-enable writes, write-first same-address reads,
// configurable read latency (1 or 2) and a sequential whole-array clear engine.
module dp_memory #(
    parameter int DATA_W = 32,
    parameter int ADD_S  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr,
    input  logic [ADD_S-1:0]      wr_add,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  rd,
    input  logic [ADD_S-1:0]      rd_add,
    input  logic                  clr,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int NB = DATA_W / 8;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]        state;
    logic [ADD_S-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [2**ADD_S];

    logic              clr_acc;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     en_b
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (en_b[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    // A clear request wins over traffic in the same cycle, and rst wins over everything.
    assign clr_acc = !rst && (state == READY) && clr;
    assign wr_acc  = !rst && (state == READY) && !clr && en && wr;
    assign rd_acc  = !rst && (state == READY) && !clr && en && rd;
    assign busy    = (state == CLEAR);

    assign wr_word = merge_bytes(mem[wr_add], data_in, be);
    assign rd_word = (wr_acc && (wr_add == rd_add)) ? merge_bytes(mem[rd_add], data_in, be)
                                                    : mem[rd_add];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADD_S'(1);
                    if (clr_cnt == '1) state <= READY;
                end
                default: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            mem[wr_add] <= wr_word;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // p0: read result registered straight into the output
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    data_out <= '0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) data_out <= rd_word;
                end
            end
        end else begin : g_lat2
            logic              vld_p0;
            logic [DATA_W-1:0] rdata_p0;

            // p0: array read captured
            always_ff @(posedge clk) begin
                if (rst) vld_p0 <= 1'b0;
                else     vld_p0 <= rd_acc;
            end

            always_ff @(posedge clk) begin
                if (rd_acc) rdata_p0 <= rd_word;
            end

            // p1: output register; an accepted clear drops the read still in p0
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    data_out <= '0;
                end else begin
                    rd_valid <= vld_p0 && !clr_acc;
                    if (vld_p0 && !clr_acc) data_out <= rdata_p0;
                end
            end
        end
    endgenerate

endmodule
